// File: rtl/fwd_pkg.sv
// Shared types for the forwarding / load-use hazard unit: per-stage entry flags,
// the register-file select code and the select-width helper.
package fwd_pkg;

  localparam int SEL_RF = 0;

  // Destination index is kept outside the struct so REG_W can stay a module parameter.
  typedef struct packed {
    logic valid;
    logic regwrite;
    logic is_load;
  } entry_flags_t;

  function automatic int sel_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fwd_match.sv
// Priority matcher for one source operand against every tracked stage.
// The youngest (lowest-index) matching writer decides the select or the hazard.
module fwd_match
  import fwd_pkg::*;
#(
  parameter int REG_W    = 3,
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 2,
  parameter int ZERO_REG = 1,
  parameter int SEL_W    = 2
) (
  input  logic [REG_W-1:0]        src,
  input  logic                    src_use,
  input  entry_flags_t [DEPTH-1:0] ent_flags,
  input  logic [DEPTH*REG_W-1:0]  ent_rd,
  output logic [SEL_W-1:0]        sel,
  output logic                    hazard
);

  logic src_live;
  logic found;

  always_comb begin
    sel      = SEL_W'(SEL_RF);
    hazard   = 1'b0;
    found    = 1'b0;
    // A hard-wired zero register never carries a dependency.
    src_live = src_use && !((ZERO_REG != 0) && (src == '0));
    for (int k = 0; k < DEPTH; k++) begin
      if (!found && src_live && ent_flags[k].valid && ent_flags[k].regwrite &&
          (ent_rd[k*REG_W +: REG_W] == src)) begin
        found = 1'b1;
        if (ent_flags[k].is_load && ((k + 1) < LOAD_LAT)) begin
          hazard = 1'b1;
        end else begin
          sel = SEL_W'(k + 1);
        end
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding select and load-use stall generation beside the decode stage.
// Keeps a shadow pipe of in-flight destinations; stage 1 is EX, stage DEPTH is WB.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int   REG_W    = 3,
  parameter int   NSRC     = 2,
  parameter int   DEPTH    = 3,
  parameter int   LOAD_LAT = 2,
  parameter int   ZERO_REG = 1,
  parameter int   CNT_W    = 16,
  localparam int  SEL_W    = sel_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_W-1:0]      id_rd,
  input  logic                  id_regwrite,
  input  logic                  id_is_load,
  input  logic [NSRC*REG_W-1:0] id_src,
  input  logic [NSRC-1:0]       id_src_use,
  input  logic                  flush,
  output logic                  stall,
  output logic [NSRC*SEL_W-1:0] fwd_sel,
  output logic [CNT_W-1:0]      stall_cycles
);

  entry_flags_t [DEPTH-1:0] ent_flags;
  logic [DEPTH*REG_W-1:0]   ent_rd;
  logic [NSRC-1:0]          hazard;
  entry_flags_t             id_entry;

  assign stall = id_valid & (|hazard);

  // A stalled or squashed decode slot enters the pipe as a bubble.
  assign id_entry = '{valid:    id_valid & ~stall & ~flush,
                      regwrite: id_regwrite,
                      is_load:  id_is_load};

  for (genvar s = 0; s < NSRC; s++) begin : g_src
    fwd_match #(
      .REG_W   (REG_W),
      .DEPTH   (DEPTH),
      .LOAD_LAT(LOAD_LAT),
      .ZERO_REG(ZERO_REG),
      .SEL_W   (SEL_W)
    ) u_match (
      .src      (id_src[s*REG_W +: REG_W]),
      .src_use  (id_src_use[s]),
      .ent_flags(ent_flags),
      .ent_rd   (ent_rd),
      .sel      (fwd_sel[s*SEL_W +: SEL_W]),
      .hazard   (hazard[s])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_flags <= '0;
      ent_rd    <= '0;
    end else begin
      if (flush) begin
        ent_flags <= '0;
      end else begin
        ent_flags[0] <= id_entry;
        for (int k = 1; k < DEPTH; k++) begin
          ent_flags[k] <= ent_flags[k-1];
        end
      end
      ent_rd[0 +: REG_W] <= id_rd;
      for (int k = 1; k < DEPTH; k++) begin
        ent_rd[k*REG_W +: REG_W] <= ent_rd[(k-1)*REG_W +: REG_W];
      end
    end
  end

  // Saturating count of stalled cycles; only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (stall && (stall_cycles != {CNT_W{1'b1}})) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: forwarding chains, load-use stall, youngest-wins,
// zero register, flush, asynchronous reset and counter saturation.
module tb_fwd_hazard_unit;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic [2:0]  id_rd;
  logic        id_regwrite;
  logic        id_is_load;
  logic [5:0]  id_src;
  logic [1:0]  id_src_use;
  logic        flush;
  logic        stall;
  logic [3:0]  fwd_sel;
  logic [15:0] stall_cycles;
  logic        stall_s;
  logic [3:0]  fwd_sel_s;
  logic [1:0]  stall_cycles_s;

  logic [4:0]  exp_q[$];
  int          checks;
  int          errors;

  fwd_hazard_unit u_dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_rd       (id_rd),
    .id_regwrite (id_regwrite),
    .id_is_load  (id_is_load),
    .id_src      (id_src),
    .id_src_use  (id_src_use),
    .flush       (flush),
    .stall       (stall),
    .fwd_sel     (fwd_sel),
    .stall_cycles(stall_cycles)
  );

  fwd_hazard_unit #(.CNT_W(2)) u_sat (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_rd       (id_rd),
    .id_regwrite (id_regwrite),
    .id_is_load  (id_is_load),
    .id_src      (id_src),
    .id_src_use  (id_src_use),
    .flush       (flush),
    .stall       (stall_s),
    .fwd_sel     (fwd_sel_s),
    .stall_cycles(stall_cycles_s)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic compare_out(input string tag);
    logic [4:0] obs;
    logic [4:0] exp;
    obs = {stall, fwd_sel};
    exp = exp_q.pop_front();
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed stall/sel %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_cnt(input logic [15:0] obs, input logic [15:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed count %0d expected %0d", tag, obs, exp);
    end
  endtask

  // driver: apply one decode slot at the falling edge, check the combinational outputs
  task automatic step(input logic v, input logic [2:0] rd, input logic rw, input logic ld,
                      input logic [2:0] s1, input logic [2:0] s0, input logic [1:0] u,
                      input logic fl, input logic es, input logic [3:0] esel,
                      input string tag);
    @(negedge clk);
    id_valid    = v;
    id_rd       = rd;
    id_regwrite = rw;
    id_is_load  = ld;
    id_src      = {s1, s0};
    id_src_use  = u;
    flush       = fl;
    exp_q.push_back({es, esel});
    #1;
    compare_out(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst         = 1'b1;
    id_valid    = 1'b0;
    id_rd       = '0;
    id_regwrite = 1'b0;
    id_is_load  = 1'b0;
    id_src      = '0;
    id_src_use  = '0;
    flush       = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    step(1, 0, 0, 0, 2, 3, 2'b11, 0, 0, 4'b0000, "reset_clean");
    check_cnt(stall_cycles, 16'd0, "reset_cnt");

    // ALU chain on r3, then r4 trailing behind
    step(1, 3, 1, 0, 1, 1, 2'b00, 0, 0, 4'b0000, "alu_wr_r3");
    step(1, 4, 1, 0, 0, 3, 2'b01, 0, 0, 4'b0001, "alu_fwd_ex");
    step(0, 0, 0, 0, 0, 3, 2'b01, 0, 0, 4'b0010, "alu_fwd_mem");
    step(0, 0, 0, 0, 4, 3, 2'b11, 0, 0, 4'b1011, "alu_fwd_wb");
    step(0, 0, 0, 0, 4, 3, 2'b11, 0, 0, 4'b1100, "alu_r3_retired");

    // load-use on r2: one stall cycle, then forward from stage 2
    step(1, 2, 1, 1, 0, 0, 2'b00, 0, 0, 4'b0000, "load_r2");
    step(1, 6, 1, 0, 2, 0, 2'b10, 0, 1, 4'b0000, "load_use_stall");
    step(1, 6, 1, 0, 2, 0, 2'b10, 0, 0, 4'b1000, "load_use_fwd");
    check_cnt(stall_cycles, 16'd1, "stall_cnt_one");
    step(0, 0, 0, 0, 2, 6, 2'b11, 0, 0, 4'b1101, "load_wb_and_alu");
    step(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 4'b0000, "drain_a");
    step(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 4'b0000, "drain_b");

    // two writers of r5
    step(1, 5, 1, 0, 0, 0, 2'b00, 0, 0, 4'b0000, "wr_r5_old");
    step(1, 1, 1, 0, 0, 0, 2'b00, 0, 0, 4'b0000, "wr_r1");
    step(1, 5, 1, 0, 0, 5, 2'b01, 0, 0, 4'b0010, "wr_r5_young");
    step(0, 0, 0, 0, 1, 5, 2'b11, 0, 0, 4'b1001, "youngest_wins");
    step(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 4'b0000, "drain_c");
    step(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 4'b0000, "drain_d");

    // zero register, immediate operand, non-writing and invalid entries
    step(1, 7, 1, 0, 0, 0, 2'b00, 0, 0, 4'b0000, "wr_r7");
    step(1, 0, 1, 0, 0, 7, 2'b00, 0, 0, 4'b0000, "imm_ignored");
    step(1, 3, 0, 0, 7, 0, 2'b11, 0, 0, 4'b1000, "zero_reg");
    step(0, 0, 0, 0, 0, 3, 2'b01, 0, 0, 4'b0000, "nonwrite_ignored");
    step(0, 5, 1, 0, 0, 0, 2'b00, 0, 0, 4'b0000, "bubble_wr_r5");
    step(0, 0, 0, 0, 0, 5, 2'b01, 0, 0, 4'b0000, "invalid_ignored");
    step(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 4'b0000, "drain_e");
    step(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 4'b0000, "drain_f");

    // id_valid low masks stall, then flush with a load in stage 1
    step(1, 4, 1, 1, 0, 0, 2'b00, 0, 0, 4'b0000, "load_r4");
    step(0, 0, 0, 0, 0, 4, 2'b01, 0, 0, 4'b0000, "no_valid_no_stall");
    step(1, 4, 1, 1, 0, 4, 2'b01, 0, 0, 4'b0010, "load_fwd_mem");
    step(1, 1, 1, 0, 0, 4, 2'b01, 1, 1, 4'b0000, "stall_during_flush");
    step(0, 0, 0, 0, 1, 4, 2'b11, 0, 0, 4'b0000, "after_flush");
    check_cnt(stall_cycles, 16'd2, "cnt_kept_by_flush");

    // asynchronous reset in the middle of a stall
    step(1, 2, 1, 1, 0, 0, 2'b00, 0, 0, 4'b0000, "load_r2_b");
    step(1, 3, 1, 0, 2, 0, 2'b10, 0, 1, 4'b0000, "stall_before_rst");
    #1;
    rst = 1'b1;
    #1;
    exp_q.push_back(5'b00000);
    compare_out("rst_async_out");
    check_cnt(stall_cycles, 16'd0, "rst_async_cnt");
    @(negedge clk);
    rst = 1'b0;
    step(1, 0, 0, 0, 0, 2, 2'b01, 0, 0, 4'b0000, "post_rst_clean");

    // five separate load-use stalls; the 2-bit counter must stop at 3
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1, 2, 1, 1, 0, 0, 2'b00, 0, 0, 4'b0000, "sat_load");
      step(1, 1, 0, 0, 0, 2, 2'b01, 0, 1, 4'b0000, "sat_stall");
      step(1, 1, 0, 0, 0, 2, 2'b01, 0, 0, 4'b0010, "sat_fwd");
      check_cnt(stall_cycles, 16'(i + 1), "cnt_wide");
      check_cnt({14'd0, stall_cycles_s}, (i + 1 > 3) ? 16'd3 : 16'(i + 1), "cnt_sat");
    end

    // report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
